// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the fetch / load-store front-ends, the shared SRAM and the arbiter.
// The arbiter takes the slave modport; requesters plus the SRAM macro sit on the master side.
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [MASK_WIDTH-1:0] mem_wr_mask;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  stall_if;
    logic                  stall_mem;

    logic                  sram_en;
    logic [MASK_WIDTH-1:0] sram_wmask;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  stall_if, stall_mem,
        input  sram_en, sram_wmask, sram_addr, sram_wdata,
        output sram_rdata
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask,
        output mem_gnt, mem_rvalid, mem_rdata,
        output stall_if, stall_mem,
        output sram_en, sram_wmask, sram_addr, sram_wdata,
        input  sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: memory port beats fetch, 1-cycle read data steered by owner.
// Optional fetch starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                clk,
    input  logic                rst,
    sram_port_arbiter_if.slave  bus
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_MEM  = 2'd2;

    logic [1:0]            r_rd_owner;
    logic [DATA_WIDTH-1:0] r_if_hold;
    logic [DATA_WIDTH-1:0] r_mem_hold;

    logic                  w_mem_req;
    logic                  w_fetch_wins;
    logic                  w_if_gnt;
    logic                  w_mem_gnt;
    logic                  w_mem_rd;
    logic [1:0]            w_rd_owner_nxt;
    logic                  w_sram_en;
    logic [MASK_WIDTH-1:0] w_sram_wmask;
    logic [ADDR_WIDTH-1:0] w_sram_addr;
    logic [DATA_WIDTH-1:0] w_sram_wdata;

    assign w_mem_req = bus.mem_rd_en | bus.mem_wr_en;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    logic [3:0] r_wait_cnt;

    assign w_fetch_wins = bus.if_req & (r_wait_cnt >= 4'(MAX_WAIT));

    // Counts consecutive stalled fetch cycles; any grant or dropped request restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!bus.if_req || w_if_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != 4'd15) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end
`else
    logic w_unused_max_wait;

    assign w_fetch_wins      = 1'b0;
    assign w_unused_max_wait = (MAX_WAIT != 0);
`endif

    assign w_mem_gnt = w_mem_req & ~w_fetch_wins;
    assign w_if_gnt  = bus.if_req & ~w_mem_gnt;
    // A simultaneous read+write is a write; the read half is dropped.
    assign w_mem_rd  = w_mem_gnt & ~bus.mem_wr_en;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_sram_en    = 1'b0;
        w_sram_wmask = '0;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        if (w_mem_gnt) begin
            w_sram_en   = 1'b1;
            w_sram_addr = bus.mem_addr;
            if (bus.mem_wr_en) begin
                w_sram_wmask = bus.mem_wr_mask;
                w_sram_wdata = bus.mem_wr_data;
            end
        end else if (w_if_gnt) begin
            w_sram_en   = 1'b1;
            w_sram_addr = bus.if_addr;
        end
    end

    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_if_gnt) begin
            w_rd_owner_nxt = OWN_IF;
        end else if (w_mem_rd) begin
            w_rd_owner_nxt = OWN_MEM;
        end
    end

    // Reset discards a read issued in the same cycle by forcing the owner to NONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner <= OWN_NONE;
            r_if_hold  <= '0;
            r_mem_hold <= '0;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
            if (r_rd_owner == OWN_IF) begin
                r_if_hold <= bus.sram_rdata;
            end
            if (r_rd_owner == OWN_MEM) begin
                r_mem_hold <= bus.sram_rdata;
            end
        end
    end

    assign bus.if_gnt     = w_if_gnt;
    assign bus.mem_gnt    = w_mem_gnt;
    assign bus.stall_if   = bus.if_req & ~w_if_gnt;
    assign bus.stall_mem  = w_mem_req & ~w_mem_gnt;

    assign bus.if_rvalid  = (r_rd_owner == OWN_IF);
    assign bus.mem_rvalid = (r_rd_owner == OWN_MEM);
    assign bus.if_rdata   = bus.if_rvalid  ? bus.sram_rdata : r_if_hold;
    assign bus.mem_rdata  = bus.mem_rvalid ? bus.sram_rdata : r_mem_hold;

    assign bus.sram_en    = w_sram_en;
    assign bus.sram_wmask = w_sram_wmask;
    assign bus.sram_addr  = w_sram_addr;
    assign bus.sram_wdata = w_sram_wdata;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model and a behavioural SRAM.
module tb_sram_port_arbiter;
    localparam int MAX_WAIT = 4;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk;
    logic rst;

    sram_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    sram_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: 256 words indexed by addr[9:2], read data registered.
    logic [31:0] sram_mem [256];
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_wmask == 4'h0) begin
                bus.sram_rdata <= sram_mem[bus.sram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.sram_wmask[b]) sram_mem[bus.sram_addr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] ref_mem [256];
    int          m_owner = 0;          // 0 none, 1 fetch, 2 memory
    logic [31:0] m_ret = '0;
    logic [31:0] m_if_hold = '0;
    logic [31:0] m_mem_hold = '0;
    int          m_wait = 0;

    logic        e_if_gnt, e_mem_gnt, e_stall_if, e_stall_mem;
    logic        e_if_rvalid, e_mem_rvalid, e_sram_en;
    logic [3:0]  e_wmask;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_mem_rdata;

    task automatic model_eval();
        logic mem_req, starve;
        mem_req      = bus.mem_rd_en || bus.mem_wr_en;
        starve       = GUARD && bus.if_req && (m_wait >= MAX_WAIT);
        e_mem_gnt    = mem_req && !starve;
        e_if_gnt     = bus.if_req && !e_mem_gnt;
        e_stall_if   = bus.if_req && !e_if_gnt;
        e_stall_mem  = mem_req && !e_mem_gnt;
        e_sram_en    = e_mem_gnt || e_if_gnt;
        e_addr       = e_mem_gnt ? bus.mem_addr : (e_if_gnt ? bus.if_addr : 32'h0);
        e_wmask      = (e_mem_gnt && bus.mem_wr_en) ? bus.mem_wr_mask : 4'h0;
        e_wdata      = (e_mem_gnt && bus.mem_wr_en) ? bus.mem_wr_data : 32'h0;
        e_if_rvalid  = (m_owner == 1);
        e_mem_rvalid = (m_owner == 2);
        e_if_rdata   = e_if_rvalid  ? m_ret : m_if_hold;
        e_mem_rdata  = e_mem_rvalid ? m_ret : m_mem_hold;
    endtask

    task automatic model_commit();
        int k;
        k = int'(e_addr[9:2]);
        if (m_owner == 1) m_if_hold  = m_ret;
        if (m_owner == 2) m_mem_hold = m_ret;
        if (e_sram_en && e_wmask == 4'h0) m_ret = ref_mem[k];
        if (e_sram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (e_wmask[b]) ref_mem[k][8*b +: 8] = e_wdata[8*b +: 8];
            end
        end
        if (rst) begin
            m_owner = 0; m_if_hold = '0; m_mem_hold = '0; m_wait = 0;
        end else begin
            m_owner = e_if_gnt ? 1 : ((e_mem_gnt && !bus.mem_wr_en) ? 2 : 0);
            if (!bus.if_req || e_if_gnt) m_wait = 0;
            else if (m_wait < 15)        m_wait = m_wait + 1;
        end
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic rd, input logic wr,
                         input logic [31:0] ma, input logic [31:0] wd, input logic [3:0] wm,
                         input logic r);
        bus.if_req = ifr; bus.if_addr = ifa;
        bus.mem_rd_en = rd; bus.mem_wr_en = wr; bus.mem_addr = ma;
        bus.mem_wr_data = wd; bus.mem_wr_mask = wm;
        rst = r;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    // Inputs are applied 1 ns after the edge; outputs are sampled 4 ns after it.
    task automatic settle();
        #3;
        model_eval();
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 32'h0, 1'b0, 1'b1, a, d, 4'hF, 1'b0);
        settle();
        tick();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] t;
        logic [3:0]  w;
        t = $urandom();
        w = 4'($urandom_range(0, 15));
        return {t[31:10], 4'h0, w, 2'b00};
    endfunction

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        settle(); tick();
        settle(); tick();
        settle();
        n_tests++; if (bus.if_rvalid !== 1'b0)   begin n_fail++; $display("FAIL reset_if_rvalid: got %b want 0", bus.if_rvalid); end
        n_tests++; if (bus.mem_rvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_rvalid: got %b want 0", bus.mem_rvalid); end
        n_tests++; if (bus.if_rdata !== 32'h0)   begin n_fail++; $display("FAIL reset_if_rdata: got %h want 0", bus.if_rdata); end
        n_tests++; if (bus.mem_rdata !== 32'h0)  begin n_fail++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_rdata); end
        n_tests++; if (bus.sram_en !== 1'b0)     begin n_fail++; $display("FAIL reset_sram_en: got %b want 0", bus.sram_en); end
        tick();
        idle(); settle(); tick();
        for (int i = 0; i < 256; i++) preload(32'(i) << 2, $urandom());
        idle(); settle(); tick();
    endtask

    task automatic test_fetch_alone();
        preload(32'h1C00_0000, 32'h02C0_0000);
        drive(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        settle();
        n_tests++; if (bus.if_gnt !== 1'b1)           begin n_fail++; $display("FAIL fetch_gnt: got %b want 1", bus.if_gnt); end
        n_tests++; if (bus.sram_wmask !== 4'h0)       begin n_fail++; $display("FAIL fetch_wmask: got %h want 0", bus.sram_wmask); end
        n_tests++; if (bus.sram_addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL fetch_addr: got %h want 1c000000", bus.sram_addr); end
        tick();
        idle(); settle();
        n_tests++; if (bus.if_rvalid !== 1'b1)        begin n_fail++; $display("FAIL fetch_rvalid: got %b want 1", bus.if_rvalid); end
        n_tests++; if (bus.if_rdata !== 32'h02C0_0000) begin n_fail++; $display("FAIL fetch_rdata: got %h want 02c00000", bus.if_rdata); end
        tick();
    endtask

    task automatic test_conflict();
        preload(32'h0000_0100, 32'hDEAD_BEEF);
        preload(32'h0000_0040, 32'hCAFE_F00D);
        drive(1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        settle();
        n_tests++; if ({bus.mem_gnt, bus.if_gnt, bus.stall_if, bus.stall_mem} !== 4'b1010)
            begin n_fail++; $display("FAIL conflict_grant: got %b want 1010", {bus.mem_gnt, bus.if_gnt, bus.stall_if, bus.stall_mem}); end
        tick();
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        settle();
        n_tests++; if (bus.mem_rvalid !== 1'b1)         begin n_fail++; $display("FAIL conflict_mem_rvalid: got %b want 1", bus.mem_rvalid); end
        n_tests++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL conflict_mem_rdata: got %h want deadbeef", bus.mem_rdata); end
        n_tests++; if (bus.if_gnt !== 1'b1)             begin n_fail++; $display("FAIL conflict_if_gnt: got %b want 1", bus.if_gnt); end
        tick();
        idle(); settle();
        n_tests++; if (bus.if_rdata !== 32'hCAFE_F00D)  begin n_fail++; $display("FAIL conflict_if_rdata: got %h want cafef00d", bus.if_rdata); end
        tick();
    endtask

    task automatic test_byte_store();
        preload(32'h0000_0200, 32'h1122_3344);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_AB00, 4'b0010, 1'b0);
        settle();
        n_tests++; if (bus.sram_wmask !== 4'b0010)      begin n_fail++; $display("FAIL store_wmask: got %b want 0010", bus.sram_wmask); end
        n_tests++; if (bus.sram_wdata !== 32'h0000_AB00) begin n_fail++; $display("FAIL store_wdata: got %h want 0000ab00", bus.sram_wdata); end
        tick();
        // Zero-mask store still takes the SRAM cycle but writes nothing.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        settle();
        n_tests++; if ({bus.mem_rvalid, bus.if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL store_no_rvalid: got %b want 00", {bus.mem_rvalid, bus.if_rvalid}); end
        n_tests++; if ({bus.mem_gnt, bus.sram_en} !== 2'b11)      begin n_fail++; $display("FAIL store_zero_mask_gnt: got %b want 11", {bus.mem_gnt, bus.sram_en}); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
        settle();
        n_tests++; if (bus.mem_rvalid !== 1'b0)         begin n_fail++; $display("FAIL store_zero_mask_rvalid: got %b want 0", bus.mem_rvalid); end
        tick();
        idle(); settle();
        n_tests++; if (bus.mem_rdata !== 32'h1122_AB44) begin n_fail++; $display("FAIL store_readback: got %h want 1122ab44", bus.mem_rdata); end
        tick();
    endtask

    task automatic test_hold();
        preload(32'h0000_0300, 32'h55AA_55AA);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1'b0);
        settle(); tick();
        idle(); settle(); tick();
        for (int i = 0; i < 3; i++) begin
            idle(); settle();
            n_tests++; if ({bus.mem_rvalid, bus.mem_rdata} !== {1'b0, 32'h55AA_55AA})
                begin n_fail++; $display("FAIL hold_%0d: got %b/%h want 0/55aa55aa", i, bus.mem_rvalid, bus.mem_rdata); end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        settle(); tick();
        idle(); settle();
        n_tests++; if (bus.if_rvalid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_if_rvalid: got %b want 0", bus.if_rvalid); end
        n_tests++; if (bus.if_rdata !== 32'h0)   begin n_fail++; $display("FAIL rstmid_if_rdata: got %h want 0", bus.if_rdata); end
        n_tests++; if (bus.mem_rdata !== 32'h0)  begin n_fail++; $display("FAIL rstmid_mem_rdata: got %h want 0", bus.mem_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        int cyc, first;
        logic gnt_mem_at, stall_mem_at;
        idle(); settle(); tick();
        cyc = 0; first = -1; gnt_mem_at = 1'bx; stall_mem_at = 1'bx;
        while (first < 0 && cyc < 10) begin
            drive(1'b1, 32'h1C00_0000, (cyc < 6), 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
            settle();
            if (bus.if_gnt === 1'b1) begin
                first = cyc; gnt_mem_at = bus.mem_gnt; stall_mem_at = bus.stall_mem;
            end
            tick();
            cyc++;
        end
        idle(); settle(); tick();
        n_tests++; if (first != (GUARD ? 4 : 6)) begin n_fail++; $display("FAIL starve_grant_cycle: got %0d want %0d", first, GUARD ? 4 : 6); end
        n_tests++; if ({gnt_mem_at, stall_mem_at} !== {1'b0, GUARD})
            begin n_fail++; $display("FAIL starve_mem_state: got %b want %b", {gnt_mem_at, stall_mem_at}, {1'b0, GUARD}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [31:0] v [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h0000_0400 + 32'(i) * 4;
            v[i] = $urandom();
            preload(a[i], v[i]);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 4)     idle();
            else if (i % 2) drive(1'b0, 32'h0, 1'b1, 1'b0, a[i], 32'h0, 4'h0, 1'b0);
            else            drive(1'b1, a[i], 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
            settle();
            if (i > 0) begin
                n_tests++;
                if (((i - 1) % 2 == 1) ? ({bus.mem_rvalid, bus.mem_rdata} !== {1'b1, v[i-1]})
                                       : ({bus.if_rvalid, bus.if_rdata} !== {1'b1, v[i-1]})) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got if %b/%h mem %b/%h want %h", i, bus.if_rvalid, bus.if_rdata, bus.mem_rvalid, bus.mem_rdata, v[i-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit          if_pend, mem_pend;
        logic        ifr, rd, wr, r;
        logic [31:0] ifa, ma, wd;
        logic [3:0]  wm;
        int          kind;
        if_pend = 0; mem_pend = 0;
        ifr = 0; rd = 0; wr = 0; ifa = '0; ma = '0; wd = '0; wm = '0;
        for (int c = 0; c < 300; c++) begin
            if (!if_pend) begin
                ifr = ($urandom_range(0, 3) != 0);
                ifa = rnd_addr();
            end
            if (!mem_pend) begin
                kind = $urandom_range(0, 9);
                rd   = (kind >= 4 && kind <= 6) || kind == 9;
                wr   = (kind >= 7);
                ma   = rnd_addr();
                wd   = $urandom();
                wm   = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            r = ($urandom_range(0, 49) == 0);
            drive(ifr, ifa, rd, wr, ma, wd, wm, r);
            settle();
            n_tests++;
            if ({bus.if_gnt, bus.mem_gnt, bus.stall_if, bus.stall_mem, bus.if_rvalid, bus.mem_rvalid, bus.sram_en} !==
                {e_if_gnt, e_mem_gnt, e_stall_if, e_stall_mem, e_if_rvalid, e_mem_rvalid, e_sram_en}) begin
                n_fail++;
                $display("FAIL rand_ctl c%0d: got %b want %b", c,
                    {bus.if_gnt, bus.mem_gnt, bus.stall_if, bus.stall_mem, bus.if_rvalid, bus.mem_rvalid, bus.sram_en},
                    {e_if_gnt, e_mem_gnt, e_stall_if, e_stall_mem, e_if_rvalid, e_mem_rvalid, e_sram_en});
            end
            n_tests++;
            if ({bus.sram_addr, bus.sram_wmask, bus.sram_wdata} !== {e_addr, e_wmask, e_wdata}) begin
                n_fail++;
                $display("FAIL rand_sram c%0d: got %h/%h/%h want %h/%h/%h", c, bus.sram_addr, bus.sram_wmask,
                    bus.sram_wdata, e_addr, e_wmask, e_wdata);
            end
            n_tests++;
            if (bus.if_rdata !== e_if_rdata) begin
                n_fail++; $display("FAIL rand_if_rdata c%0d: got %h want %h", c, bus.if_rdata, e_if_rdata);
            end
            n_tests++;
            if (bus.mem_rdata !== e_mem_rdata) begin
                n_fail++; $display("FAIL rand_mem_rdata c%0d: got %h want %h", c, bus.mem_rdata, e_mem_rdata);
            end
            if_pend  = ifr && !e_if_gnt;
            mem_pend = (rd || wr) && !e_mem_gnt;
            tick();
        end
        idle(); settle(); tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        test_reset();
        test_fetch_alone();
        test_conflict();
        test_byte_store();
        test_hold();
        test_reset_mid_read();
        test_starvation();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single-port unified SRAM between the instruction-fetch port and the memory-access (load/store) port. Sits between the two pipeline front-ends and the `sram_if` master side: it grants one requester per cycle, drives the SRAM, steers 1-cycle-latency read data back to its owner, and raises per-port stalls for the loser. An optional starvation guard bounds how long fetch can be locked out by back-to-back memory traffic.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data word width; byte mask width is `DATA_WIDTH/8`.
- `MAX_WAIT`, 4, starvation-guard threshold in consecutive denied fetch cycles (1..15).

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch read request.
- `if_addr` in ADDR_WIDTH: fetch address, word-aligned.
- `if_gnt` out 1: fetch granted this cycle.
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out DATA_WIDTH: fetch read data, held.
- `mem_rd_en` in 1: load request.
- `mem_wr_en` in 1: store request.
- `mem_addr` in ADDR_WIDTH: load/store address, word-aligned.
- `mem_wr_data` in DATA_WIDTH: store data, pre-shifted into lanes.
- `mem_wr_mask` in DATA_WIDTH/8: store byte mask.
- `mem_gnt` out 1: memory port granted this cycle.
- `mem_rvalid` out 1: load data valid.
- `mem_rdata` out DATA_WIDTH: load data, held.
- `stall_if` out 1: `if_req & ~if_gnt`.
- `stall_mem` out 1: `(mem_rd_en|mem_wr_en) & ~mem_gnt`.
- `sram_en` out 1: SRAM access enable.
- `sram_wmask` out DATA_WIDTH/8: byte write mask; zero means read.
- `sram_addr` out ADDR_WIDTH: SRAM address.
- `sram_wdata` out DATA_WIDTH: SRAM write data.
- `sram_rdata` in DATA_WIDTH: SRAM read data, valid one cycle after a read.

## Operation
- Grant is combinational per cycle. Default priority: memory port over fetch (an older instruction in flight wins).
- Memory request with `mem_wr_en=1`: write, `sram_wmask=mem_wr_mask`. `mem_rd_en` and `mem_wr_en` both high is a protocol violation; treated as a write and the read is dropped.
- Store with `mem_wr_mask=0`: granted and consumes the cycle, `sram_en=1`, no byte written.
- Read owner register `rd_owner` (NONE/IF/MEM) records the owner of the read issued this cycle; next cycle `sram_rdata` is copied into that port's hold register and its `*_rvalid` pulses for one cycle.
- `if_rdata`/`mem_rdata` are the hold registers: stable until the next read returns to that port. `*_rvalid` is combinationally `rd_owner==port`; `*_rdata` muxes `sram_rdata` when `*_rvalid`, else the hold register.
- Writes produce no rvalid. No request: `sram_en=0`, outputs to SRAM zero.
- Starvation counter `wait_cnt` (4 bits): increments each cycle `stall_if=1`, saturates at 15, clears on `if_gnt` or `if_req=0`.

## Timing
- Grant and SRAM drive: 0 cycles (same cycle as request). Read data: exactly 1 cycle after grant.
- Back-to-back reads from alternating owners are fully pipelined: one SRAM access per cycle, each return steered by its own `rd_owner`.
- A requester must hold its request and operands stable until its `*_gnt`.
- Reset: `rd_owner=NONE`, `wait_cnt=0`, both hold registers 0, so `if_rvalid=mem_rvalid=0`, `if_rdata=mem_rdata=0`; `sram_en=0` whenever no request. A read issued the cycle `rst` is asserted is discarded: no rvalid follows.
- Hold registers update only on returning reads; grants during reset are ignored.

## Configuration
- `SRAM_ARB_STARVE_GUARD_EN` defined: when `wait_cnt >= MAX_WAIT` and `if_req=1`, fetch wins that cycle over the memory port (memory port stalls); `wait_cnt` then clears.
- Not defined: strict memory priority; `wait_cnt` is not built and fetch may be starved indefinitely.

## Test plan
- Fetch alone: `if_req=1`, `if_addr=0x1C000000`, SRAM word 0x02C00000 -> `if_gnt=1` in cycle 0, `if_rvalid=1`, `if_rdata=0x02C00000` in cycle 1, `sram_wmask=0`.
- Conflict: `if_req=1` and `mem_rd_en=1` at 0x100 (word 0xDEADBEEF) in the same cycle -> `mem_gnt=1`, `stall_if=1`; next cycle `mem_rvalid=1`, `mem_rdata=0xDEADBEEF`, fetch granted.
- Byte store: `mem_wr_en=1`, addr 0x200, data 0x0000AB00, mask 0b0010 over 0x11223344 -> `sram_wmask=0b0010`, no rvalid; later read of 0x200 returns 0x1122AB44.
- Hold: load returns 0x55AA55AA, then 3 idle cycles -> `mem_rdata` stays 0x55AA55AA, `mem_rvalid=0`.
- Reset mid-read: grant fetch read, assert `rst` that cycle -> next cycle `if_rvalid=0`, `if_rdata=0`.
- Starvation (macro defined, `MAX_WAIT=4`): `mem_rd_en` held 6 cycles, `if_req` held -> fetch granted in cycle 4, memory stalled that cycle; macro undefined -> fetch granted only in cycle 6.
